// File: rtl/sbd_iter_seq_pkg.sv
// sbd_iter_seq_pkg: shared state encoding, mode codes, default iteration counts
// and the registered strobe decode for the iterative sqrt/div sequencer.
package sbd_iter_seq_pkg;
    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_LOAD   = 5'b00010;
    localparam logic [4:0] S_STEP_A = 5'b00100;
    localparam logic [4:0] S_STEP_B = 5'b01000;
    localparam logic [4:0] S_DONE   = 5'b10000;

    localparam logic MODE_SQRT = 1'b0;
    localparam logic MODE_DIV  = 1'b1;

    localparam int ITERS_SQRT_DEF = 25;
    localparam int ITERS_DIV_DEF  = 24;
    localparam int CNT_W_DEF      = 6;

    typedef struct packed {
        logic init;
        logic enr;
        logic enl;
        logic en_d;
        logic dleft;
        logic lsr;
        logic val_out;
        logic rdy_in;
    } strb_t;

    // The first STEP_A of an op has no previous digit to shift, hence cnt_nz.
    function automatic strb_t decode(input logic [4:0] st, input logic cnt_nz);
        return '{init:    st == S_LOAD,
                 enr:     st == S_STEP_A,
                 enl:     st == S_STEP_A,
                 en_d:    st == S_STEP_B || (st == S_STEP_A && cnt_nz),
                 dleft:   st == S_STEP_A && cnt_nz,
                 lsr:     st == S_STEP_B,
                 val_out: st == S_DONE,
                 rdy_in:  st == S_IDLE};
    endfunction
endpackage

// File: rtl/sbd_iter_counter.sv
// sbd_iter_counter: iteration counter with clear, saturating increment and
// terminal compare against the mode-selected iteration limit.
module sbd_iter_counter #(
    parameter int CNT_W      = 6,
    parameter int ITERS_SQRT = 25,
    parameter int ITERS_DIV  = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             mode_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] nxt_o,
    output logic             term_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d, limit;

    assign limit  = mode_i ? CNT_W'(ITERS_DIV) : CNT_W'(ITERS_SQRT);
    assign term_o = cnt_q == limit;
    assign cnt_d  = clr_i ? '0 : (inc_i && !term_o) ? cnt_q + 1'b1 : cnt_q;
    assign cnt_o  = cnt_q;
    assign nxt_o  = cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sbd_iter_seq_ctrl.sv
// sbd_iter_seq_ctrl: one-op-in-flight sequencer driving load/shift/enable strobes
// for the iterative sqrt/divide datapaths, with valid/ready on both sides and abort.
module sbd_iter_seq_ctrl
    import sbd_iter_seq_pkg::*;
#(
    parameter int ITERS_SQRT = ITERS_SQRT_DEF,
    parameter int ITERS_DIV  = ITERS_DIV_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             VAL_IN,
    output logic             RDY_IN,
    input  logic             MODE_IN,
    input  logic             ABORT,
    output logic             INIT,
    output logic             ENR,
    output logic             ENL,
    output logic             EN_D,
    output logic             DLEFT,
    output logic             LSR,
    output logic [CNT_W-1:0] ITER_IDX,
    output logic             MODE_Q,
    output logic             VAL_OUT,
    input  logic             RDY_OUT
);
    localparam int LIM_MAX = (1 << CNT_W) - 1;

    if (CNT_W < 1 || ITERS_SQRT < 1 || ITERS_DIV < 1 ||
        ITERS_SQRT > LIM_MAX || ITERS_DIV > LIM_MAX) begin : g_bad_params
        $error("sbd_iter_seq_ctrl: ITERS_SQRT/ITERS_DIV must lie in [1, 2**CNT_W-1]");
    end

    logic [4:0]       state_q, state_d;
    logic             mode_q;
    strb_t            strb_q;
    logic             accept, term;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    assign accept = VAL_IN && state_q == S_IDLE && !ABORT;

    sbd_iter_counter #(.CNT_W(CNT_W), .ITERS_SQRT(ITERS_SQRT), .ITERS_DIV(ITERS_DIV)) u_cnt (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .clr_i  (accept || ABORT),
        .inc_i  (state_q == S_STEP_A && !ABORT),
        .mode_i (mode_q),
        .cnt_o  (cnt),
        .nxt_o  (cnt_nxt),
        .term_o (term)
    );

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = accept ? S_LOAD : S_IDLE;
            S_LOAD:   state_d = S_STEP_A;
            S_STEP_A: state_d = S_STEP_B;
            S_STEP_B: state_d = term ? S_DONE : S_STEP_A;
            S_DONE:   state_d = RDY_OUT ? S_IDLE : S_DONE;
            default:  state_d = S_IDLE;
        endcase
        if (ABORT) state_d = S_IDLE;
    end

    // Strobes are decoded from next state/count and registered, so they are
    // Moore outputs of the current state yet come straight from flops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_SQRT;
            strb_q  <= decode(S_IDLE, 1'b0);
        end else begin
            state_q <= state_d;
            mode_q  <= accept ? MODE_IN : mode_q;
            strb_q  <= decode(state_d, |cnt_nxt);
        end
    end

    assign INIT     = strb_q.init;
    assign ENR      = strb_q.enr;
    assign ENL      = strb_q.enl;
    assign EN_D     = strb_q.en_d;
    assign DLEFT    = strb_q.dleft;
    assign LSR      = strb_q.lsr;
    assign VAL_OUT  = strb_q.val_out;
    assign RDY_IN   = strb_q.rdy_in;
    assign ITER_IDX = cnt;
    assign MODE_Q   = mode_q;
endmodule

// File: tb/tb_sbd_iter_seq_ctrl.sv
// tb_sbd_iter_seq_ctrl: vector table of whole operations scored through a queue,
// plus hand sequences for abort, async reset and the single-iteration build.
module tb_sbd_iter_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic val_in = 0, mode_in = 0, abort = 0, rdy_out = 0;
    logic rdy_in, init, enr, enl, en_d, dleft, lsr, mode_q, val_out;
    logic [5:0] iter_idx;
    logic [7:0] o0;
    assign o0 = {init, enr, enl, en_d, dleft, lsr, val_out, rdy_in};

    logic v1 = 0, m1 = 0, a1 = 0, r1 = 0;
    logic rdy_in1, init1, enr1, enl1, en_d1, dleft1, lsr1, mode_q1, val_out1;
    logic [1:0] iter1;
    logic [7:0] o1;
    assign o1 = {init1, enr1, enl1, en_d1, dleft1, lsr1, val_out1, rdy_in1};

    sbd_iter_seq_ctrl dut0 (
        .CLK(clk), .RST_N(rst_n), .VAL_IN(val_in), .RDY_IN(rdy_in), .MODE_IN(mode_in),
        .ABORT(abort), .INIT(init), .ENR(enr), .ENL(enl), .EN_D(en_d), .DLEFT(dleft),
        .LSR(lsr), .ITER_IDX(iter_idx), .MODE_Q(mode_q), .VAL_OUT(val_out), .RDY_OUT(rdy_out)
    );

    sbd_iter_seq_ctrl #(.ITERS_SQRT(1), .ITERS_DIV(2), .CNT_W(2)) dut1 (
        .CLK(clk), .RST_N(rst_n), .VAL_IN(v1), .RDY_IN(rdy_in1), .MODE_IN(m1),
        .ABORT(a1), .INIT(init1), .ENR(enr1), .ENL(enl1), .EN_D(en_d1), .DLEFT(dleft1),
        .LSR(lsr1), .ITER_IDX(iter1), .MODE_Q(mode_q1), .VAL_OUT(val_out1), .RDY_OUT(r1)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        bit mode;
        int bp;
        int lat;
        int n_enr;
        int n_lsr;
        int n_end;
        int n_dl;
    } vec_t;

    typedef struct {
        logic [7:0] o;
        int         it;
    } cyc_t;

    vec_t sb[$];
    vec_t vecs[4];
    cyc_t tab1[6];

    // Called on a negedge with dut0 idle; runs one op to completion.
    task automatic run_op(input vec_t v);
        vec_t e;
        int k = 0, lat = 0, hold = 0, n_init = 0, n_enr = 0, n_lsr = 0, n_end = 0, n_dl = 0;
        bit busy_ok = 1, mode_ok = 1, fin = 0;
        sb.push_back(v);
        val_in = 1; mode_in = v.mode; rdy_out = 0;
        @(posedge clk);
        while (!fin && k < 300) begin
            @(negedge clk);
            k++;
            val_in = 1'($urandom);
            mode_in = 1'($urandom);
            if (mode_q != v.mode) mode_ok = 0;
            if (val_out) begin
                if (lat == 0) lat = k;
                hold++;
                if (o0[7:2] != 0 || rdy_in) busy_ok = 0;
                rdy_out = (hold == v.bp + 1);
            end else if (lat != 0) begin
                fin = 1;
            end else begin
                n_init += int'(init); n_enr += int'(enr); n_lsr += int'(lsr);
                n_end += int'(en_d); n_dl += int'(dleft);
                if (rdy_in) busy_ok = 0;
            end
        end
        val_in = 0; mode_in = 0; rdy_out = 0;
        chk("op_finished", int'(fin), 1);
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("val_hold", hold, e.bp + 1);
        chk("init_pulses", n_init, 1);
        chk("enr_pulses", n_enr, e.n_enr);
        chk("lsr_pulses", n_lsr, e.n_lsr);
        chk("en_d_pulses", n_end, e.n_end);
        chk("dleft_pulses", n_dl, e.n_dl);
        chk("busy_quiet", int'(busy_ok), 1);
        chk("mode_q_held", int'(mode_ok), 1);
        chk("idle_after", int'(rdy_in), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        vecs[0] = '{0, 0, 52, 25, 25, 49, 24};
        vecs[1] = '{1, 0, 50, 24, 24, 47, 23};
        vecs[2] = '{0, 10, 52, 25, 25, 49, 24};
        vecs[3] = '{1, 3, 50, 24, 24, 47, 23};
        tab1[0] = '{8'b1000_0000, 0};
        tab1[1] = '{8'b0110_0000, 0};
        tab1[2] = '{8'b0001_0100, 1};
        tab1[3] = '{8'b0000_0010, 1};
        tab1[4] = '{8'b0000_0001, 1};
        tab1[5] = '{8'b1000_0000, 0};

        #1 rst_n = 0;
        #10;
        chk("rst_out0", o0, 8'b0000_0001);
        chk("rst_idx0", iter_idx, 0);
        chk("rst_mode0", mode_q, 0);
        chk("rst_out1", o1, 8'b0000_0001);
        @(negedge clk) rst_n = 1;
        @(negedge clk);

        v1 = 1; m1 = 0; r1 = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("small_out_c%0d", i + 1), o1, tab1[i].o);
            chk($sformatf("small_idx_c%0d", i + 1), iter1, tab1[i].it);
        end
        v1 = 0;

        for (int i = 0; i < 4; i++) run_op(vecs[i]);

        val_in = 1; mode_in = 0;
        @(posedge clk);
        @(negedge clk);
        val_in = 0; k = 1;
        while (k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("abort_pre_idx", iter_idx, 9);
        chk("abort_pre_en_d", en_d, 1);
        abort = 1;
        @(negedge clk);
        chk("abort_idle_out", o0, 8'b0000_0001);
        chk("abort_idx", iter_idx, 0);
        val_in = 1;
        @(negedge clk);
        chk("abort_blocks_accept", o0, 8'b0000_0001);
        abort = 0; val_in = 0;
        run_op(vecs[0]);

        val_in = 1; mode_in = 1;
        @(posedge clk);
        @(negedge clk);
        val_in = 0; k = 1;
        while (k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("pre_reset_enr", enr, 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_out", o0, 8'b0000_0001);
        chk("async_rst_idx", iter_idx, 0);
        chk("async_rst_mode", mode_q, 0);
        @(negedge clk) rst_n = 1;
        @(negedge clk);
        chk("post_rst_idle", o0, 8'b0000_0001);
        run_op(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
